// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states, default memory depth.
package mips_mem_pkg;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 32;

    typedef enum logic [2:0] {
        OpLw  = 3'b000,
        OpLh  = 3'b001,
        OpLhu = 3'b010,
        OpLb  = 3'b011,
        OpLbu = 3'b100,
        OpSw  = 3'b101,
        OpSh  = 3'b110,
        OpSb  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StRead  = 3'b001,
        StWrite = 3'b010,
        StDone  = 3'b011,
        StFault = 3'b100
    } state_e;

    // Loads are the five lowest encodings.
    function automatic logic is_load(input op_e op);
        return (op == OpLw) || (op == OpLh) || (op == OpLhu) ||
               (op == OpLb) || (op == OpLbu);
    endfunction

    // Words need a 4-byte boundary, halfwords a 2-byte boundary, bytes are always aligned.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if ((op == OpLw) || (op == OpSw)) begin
            mis = (addr_lo != 2'b00);
        end else if ((op == OpLh) || (op == OpLhu) || (op == OpSh)) begin
            mis = addr_lo[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane merge for stores.
module byte_lane_align
    import mips_mem_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Pick the addressed byte and halfword out of the memory word.
    always_comb begin
        lane_byte = rdata_i[7:0];
        unique case (byte_off_i)
            2'd0: lane_byte = rdata_i[7:0];
            2'd1: lane_byte = rdata_i[15:8];
            2'd2: lane_byte = rdata_i[23:16];
            2'd3: lane_byte = rdata_i[31:24];
            default: lane_byte = rdata_i[7:0];
        endcase
        lane_half = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend the selected lane to a full load result.
    always_comb begin
        load_data_o = rdata_i;
        case (op_i)
            OpLh:    load_data_o = {{16{lane_half[15]}}, lane_half};
            OpLhu:   load_data_o = {16'h0000, lane_half};
            OpLb:    load_data_o = {{24{lane_byte[7]}}, lane_byte};
            OpLbu:   load_data_o = {24'h000000, lane_byte};
            default: load_data_o = rdata_i;
        endcase
    end

    // Merge store data into the read word, leaving untouched lanes intact.
    always_comb begin
        store_data_o = wdata_i;
        case (op_i)
            OpSh: begin
                store_data_o = byte_off_i[1] ? {wdata_i[15:0], rdata_i[15:0]}
                                             : {rdata_i[31:16], wdata_i[15:0]};
            end
            OpSb: begin
                store_data_o = rdata_i;
                unique case (byte_off_i)
                    2'd0: store_data_o[7:0]   = wdata_i[7:0];
                    2'd1: store_data_o[15:8]  = wdata_i[7:0];
                    2'd2: store_data_o[23:16] = wdata_i[7:0];
                    2'd3: store_data_o[31:24] = wdata_i[7:0];
                    default: store_data_o = rdata_i;
                endcase
            end
            default: store_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time to a word-addressed memory, with sub-word
// loads/stores (read-modify-write for SH/SB) and alignment/range fault reporting.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Ready,
    output logic        Done,
    output logic [31:0] RData,
    output logic        Misaligned,
    output logic        OutOfRange,
    output logic [31:0] Mem_Adress,
    output logic [31:0] Mem_Write_Data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] Mem_Read_Data
);

    state_e      state_q;
    op_e         op_q;
    logic [1:0]  byte_off_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        done_q;
    logic        misaligned_q;
    logic        out_of_range_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;

    op_e         req_op;
    logic        req_misaligned;
    logic        req_out_of_range;
    logic [31:0] load_data;
    logic [31:0] store_data;

    // Classify the incoming request before it is accepted.
    always_comb begin
        req_op           = op_e'(Op);
        req_misaligned   = is_misaligned(req_op, Addr[1:0]);
        req_out_of_range = ({2'b00, Addr[31:2]} >= DEPTH_WORDS);
    end

    byte_lane_align u_align (
        .op_i         (op_q),
        .byte_off_i   (byte_off_q),
        .rdata_i      (Mem_Read_Data),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    // Access sequencer; every handshake and memory strobe is a registered output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= StIdle;
            op_q           <= OpLw;
            byte_off_q     <= 2'b00;
            wdata_q        <= 32'h0;
            ready_q        <= 1'b1;
            done_q         <= 1'b0;
            misaligned_q   <= 1'b0;
            out_of_range_q <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            rdata_q        <= 32'h0;
        end else begin
            // Pulses default low and are re-asserted only by the state that owns them.
            done_q         <= 1'b0;
            misaligned_q   <= 1'b0;
            out_of_range_q <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (Req) begin
                        op_q       <= req_op;
                        byte_off_q <= Addr[1:0];
                        wdata_q    <= WData;
                        mem_addr_q <= {2'b00, Addr[31:2]};
                        ready_q    <= 1'b0;
                        if (req_misaligned) begin
                            state_q      <= StFault;
                            misaligned_q <= 1'b1;
                            done_q       <= 1'b1;
                        end else if (req_out_of_range) begin
                            state_q        <= StFault;
                            out_of_range_q <= 1'b1;
                            done_q         <= 1'b1;
                        end else if (req_op == OpSw) begin
                            state_q     <= StWrite;
                            mem_wdata_q <= WData;
                            mem_write_q <= 1'b1;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_q    <= StRead;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (is_load(op_q)) begin
                        rdata_q <= load_data;
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        mem_wdata_q <= store_data;
                        state_q     <= StWrite;
                        mem_write_q <= 1'b1;
                    end
                end
                StWrite: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                default: begin
                    // StDone / StFault: one cycle, then back to accepting.
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign Ready          = ready_q;
    assign Done           = done_q;
    assign RData          = rdata_q;
    assign Misaligned     = misaligned_q;
    assign OutOfRange     = out_of_range_q;
    assign Mem_Adress     = mem_addr_q;
    assign Mem_Write_Data = mem_wdata_q;
    assign MemWrite       = mem_write_q;
    assign MemRead        = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 32-word behavioural memory.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Req = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WData = 32'h0;
    logic        Ready, Done, Misaligned, OutOfRange, MemWrite, MemRead;
    logic [31:0] RData, Mem_Adress, Mem_Write_Data, Mem_Read_Data;

    logic [31:0] mem [32];
    bit          mem_init;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 Clk = ~Clk;

    load_store_unit #(.DEPTH_WORDS(32)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Req            (Req),
        .Op             (Op),
        .Addr           (Addr),
        .WData          (WData),
        .Ready          (Ready),
        .Done           (Done),
        .RData          (RData),
        .Misaligned     (Misaligned),
        .OutOfRange     (OutOfRange),
        .Mem_Adress     (Mem_Adress),
        .Mem_Write_Data (Mem_Write_Data),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .Mem_Read_Data  (Mem_Read_Data)
    );

    assign Mem_Read_Data = (Mem_Adress < 32'd32) ? mem[Mem_Adress[4:0]] : 32'h0;

    // Memory: preloaded on the first clock, then written while MemWrite is high.
    always @(posedge Clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hDEAD_0000 | i;
            mem[3]   <= 32'h8899_AABB;
            mem_init <= 1'b1;
        end else if (MemWrite && (Mem_Adress < 32'd32)) begin
            mem[Mem_Adress[4:0]] <= Mem_Write_Data;
        end
    end

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    // Present a request for one edge; returns in the cycle after acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        Req = 1'b1; Op = op; Addr = addr; WData = wd;
        step();
        Req = 1'b0;
    endtask

    task automatic test_reset;
        #2 Reset = 1'b1;
        step();
        step();
        n_checks++; if (Ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", Ready); end
        n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", Done); end
        n_checks++; if ({Misaligned, OutOfRange} !== 2'b00) begin n_errors++; $display("FAIL reset_faults: got %b want 00", {Misaligned, OutOfRange}); end
        n_checks++; if ({MemWrite, MemRead} !== 2'b00) begin n_errors++; $display("FAIL reset_strobes: got %b want 00", {MemWrite, MemRead}); end
        n_checks++; if (Mem_Adress !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", Mem_Adress); end
        n_checks++; if (Mem_Write_Data !== 32'h0) begin n_errors++; $display("FAIL reset_wdata: got %h want 0", Mem_Write_Data); end
        n_checks++; if (RData !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", RData); end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_lw;
        issue(OpLw, 32'h0000_000C, 32'h0);
        n_checks++; if ({MemRead, MemWrite, Done, Ready} !== 4'b1000) begin n_errors++; $display("FAIL lw_read_cycle: got rd/wr/done/rdy %b want 1000", {MemRead, MemWrite, Done, Ready}); end
        n_checks++; if (Mem_Adress !== 32'd3) begin n_errors++; $display("FAIL lw_addr: got %h want 3", Mem_Adress); end
        step();
        n_checks++; if ({MemRead, Done} !== 2'b01) begin n_errors++; $display("FAIL lw_done_cycle: got rd/done %b want 01", {MemRead, Done}); end
        n_checks++; if (RData !== 32'h8899_AABB) begin n_errors++; $display("FAIL lw_rdata: got %h want 8899aabb", RData); end
        step();
        n_checks++; if ({Done, Ready} !== 2'b01) begin n_errors++; $display("FAIL lw_idle: got done/rdy %b want 01", {Done, Ready}); end
        last_rdata = 32'h8899_AABB;
    endtask

    task automatic test_load_ext;
        logic [2:0]  ops  [9];
        logic [31:0] adrs [9];
        logic [31:0] exps [9];
        ops = '{OpLb, OpLbu, OpLhu, OpLh, OpLb, OpLbu, OpLh, OpLhu, OpLw};
        adrs = '{32'h0F, 32'h0F, 32'h0E, 32'h0E, 32'h0C, 32'h0D, 32'h0C, 32'h0C, 32'h7C};
        exps = '{32'hFFFF_FF88, 32'h0000_0088, 32'h0000_8899, 32'hFFFF_8899,
                 32'hFFFF_FFBB, 32'h0000_00AA, 32'hFFFF_AABB, 32'h0000_AABB, 32'hDEAD_001F};
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], adrs[i], 32'h0);
            step();
            n_checks++; if ({Done, RData} !== {1'b1, exps[i]}) begin n_errors++; $display("FAIL load_ext[%0d]: got done=%b rdata=%h want done=1 rdata=%h", i, Done, RData, exps[i]); end
            step();
        end
        last_rdata = 32'hDEAD_001F;
    endtask

    task automatic test_store;
        issue(OpSb, 32'h0D, 32'h0000_0011);
        n_checks++; if ({MemRead, MemWrite} !== 2'b10) begin n_errors++; $display("FAIL sb_read: got rd/wr %b want 10", {MemRead, MemWrite}); end
        step();
        n_checks++; if ({MemRead, MemWrite, Done} !== 3'b010) begin n_errors++; $display("FAIL sb_write: got rd/wr/done %b want 010", {MemRead, MemWrite, Done}); end
        n_checks++; if (Mem_Write_Data !== 32'h8899_11BB) begin n_errors++; $display("FAIL sb_wdata: got %h want 889911bb", Mem_Write_Data); end
        step();
        n_checks++; if ({MemWrite, Done} !== 2'b01) begin n_errors++; $display("FAIL sb_done: got wr/done %b want 01", {MemWrite, Done}); end
        n_checks++; if (mem[3] !== 32'h8899_11BB) begin n_errors++; $display("FAIL sb_mem: got %h want 889911bb", mem[3]); end
        n_checks++; if (RData !== last_rdata) begin n_errors++; $display("FAIL sb_rdata_kept: got %h want %h", RData, last_rdata); end
        step();
        issue(OpSh, 32'h0E, 32'hCAFE_1234);
        step(); step(); step();
        n_checks++; if (mem[3] !== 32'h1234_11BB) begin n_errors++; $display("FAIL sh_mem: got %h want 123411bb", mem[3]); end
        issue(OpSw, 32'h0C, 32'h8899_AABB);
        n_checks++; if ({MemRead, MemWrite, Mem_Write_Data} !== {2'b01, 32'h8899_AABB}) begin n_errors++; $display("FAIL sw_write: got rd/wr %b data %h want 01 8899aabb", {MemRead, MemWrite}, Mem_Write_Data); end
        step();
        n_checks++; if ({Done, mem[3]} !== {1'b1, 32'h8899_AABB}) begin n_errors++; $display("FAIL sw_done: got done=%b mem=%h want 1 8899aabb", Done, mem[3]); end
        step();
    endtask

    task automatic test_fault;
        issue(OpLh, 32'h0D, 32'h0);
        n_checks++; if ({Done, Misaligned, OutOfRange, MemRead, MemWrite} !== 5'b11000) begin n_errors++; $display("FAIL lh_misaligned: got done/mis/oor/rd/wr %b want 11000", {Done, Misaligned, OutOfRange, MemRead, MemWrite}); end
        n_checks++; if (RData !== last_rdata) begin n_errors++; $display("FAIL fault_rdata_kept: got %h want %h", RData, last_rdata); end
        step();
        n_checks++; if ({Ready, Done, Misaligned} !== 3'b100) begin n_errors++; $display("FAIL fault_return: got rdy/done/mis %b want 100", {Ready, Done, Misaligned}); end
        issue(OpLw, 32'h80, 32'h0);
        n_checks++; if ({Done, Misaligned, OutOfRange, MemRead} !== 4'b1010) begin n_errors++; $display("FAIL lw_out_of_range: got done/mis/oor/rd %b want 1010", {Done, Misaligned, OutOfRange, MemRead}); end
        step();
        issue(OpSw, 32'h81, 32'h0);
        n_checks++; if ({Done, Misaligned, OutOfRange, MemWrite} !== 4'b1100) begin n_errors++; $display("FAIL fault_priority: got done/mis/oor/wr %b want 1100", {Done, Misaligned, OutOfRange, MemWrite}); end
        step();
    endtask

    task automatic test_reset_abort;
        issue(OpSh, 32'h0C, 32'h0000_5555);
        n_checks++; if (MemRead !== 1'b1) begin n_errors++; $display("FAIL abort_read_started: got %b want 1", MemRead); end
        #2 Reset = 1'b1;
        #1;
        n_checks++; if ({MemRead, MemWrite, Done, Ready} !== 4'b0001) begin n_errors++; $display("FAIL abort_immediate: got rd/wr/done/rdy %b want 0001", {MemRead, MemWrite, Done, Ready}); end
        step();
        Reset = 1'b0;
        step();
        n_checks++; if ({Done, Ready, MemWrite} !== 3'b010) begin n_errors++; $display("FAIL abort_after: got done/rdy/wr %b want 010", {Done, Ready, MemWrite}); end
        n_checks++; if (mem[3] !== 32'h8899_AABB) begin n_errors++; $display("FAIL abort_mem: got %h want 8899aabb", mem[3]); end
        last_rdata = 32'h0;
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp_rd, exp_done, exp_rdy;
        int done_count;
        exp_rd = 6'b001001;
        exp_done = 6'b010010;
        exp_rdy = 6'b100100;
        done_count = 0;
        Req = 1'b1; Op = OpLw; Addr = 32'h0C; WData = 32'h0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Done === 1'b1) done_count++;
            n_checks++; if ({MemRead, Done, Ready} !== {exp_rd[i], exp_done[i], exp_rdy[i]}) begin n_errors++; $display("FAIL b2b_cycle[%0d]: got rd/done/rdy %b want %b", i, {MemRead, Done, Ready}, {exp_rd[i], exp_done[i], exp_rdy[i]}); end
        end
        Req = 1'b0;
        step();
        n_checks++; if ({MemRead, Ready} !== 2'b01) begin n_errors++; $display("FAIL b2b_no_extra: got rd/rdy %b want 01", {MemRead, Ready}); end
        n_checks++; if (done_count != 2) begin n_errors++; $display("FAIL b2b_done_count: got %0d want 2", done_count); end
        n_checks++; if (RData !== 32'h8899_AABB) begin n_errors++; $display("FAIL b2b_rdata: got %h want 8899aabb", RData); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_fault();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 32, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port Clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports Req in 1 (access request), Op in 3 (LW=000, LH=001, LHU=010, LB=011, LBU=100, SW=101, SH=110, SB=111), Addr in 32 (byte address), WData in 32 (store data, low-order bits used for SH/SB).
REQ-005 SHALL have ports Ready out 1 (idle, can accept), Done out 1 (one-cycle completion pulse), RData out 32 (load result), Misaligned out 1, OutOfRange out 1.
REQ-006 SHALL have memory-side ports Mem_Adress out 32 (word index), Mem_Write_Data out 32, MemWrite out 1, MemRead out 1, Mem_Read_Data in 32; the memory reads combinationally and writes level-sensitively while MemWrite=1.

Function
REQ-007 SHALL implement FSM states IDLE, READ, WRITE, DONE, FAULT; Ready=1 only in IDLE.
REQ-008 SHALL accept a request on a rising edge with Req=1 and Ready=1, latching Op, Addr and WData; Req while Ready=0 SHALL be ignored.
REQ-009 SHALL check alignment at accept: LW/SW need Addr[1:0]=00, LH/LHU/SH need Addr[0]=0; violation -> FAULT with Misaligned=1.
REQ-010 SHALL check range at accept: Addr[31:2] >= DEPTH_WORDS -> FAULT with OutOfRange=1; misalignment takes priority when both apply.
REQ-011 FAULT SHALL last one cycle with Done=1, no MemRead/MemWrite, RData unchanged, then return to IDLE.
REQ-012 Loads SHALL be IDLE -> READ (MemRead=1 one cycle, RData captured at end) -> DONE (Done=1) -> IDLE; Done appears two cycles after accept.
REQ-013 SW SHALL be IDLE -> WRITE (MemWrite=1 one cycle) -> DONE -> IDLE.
REQ-014 SH/SB SHALL read-modify-write: IDLE -> READ -> WRITE -> DONE -> IDLE, merging new byte/halfword into the read word, other lanes preserved.
REQ-015 Byte lanes SHALL be little-endian: byte k=Addr[1:0] occupies bits [8k+7:8k]; halfword Addr[1] selects bits [15:0] or [31:16].
REQ-016 LB/LH SHALL sign-extend, LBU/LHU zero-extend, to 32 bits.
REQ-017 Mem_Adress SHALL equal Addr[31:2] zero-extended, registered, changing only in IDLE, held stable from accept until return to IDLE.
REQ-018 MemWrite, MemRead, Mem_Write_Data SHALL be registered (glitch-free); MemWrite and MemRead never both 1; Mem_Write_Data stable throughout MemWrite=1.
REQ-019 RData SHALL hold its last load value until the next completed load; stores do not alter it.
REQ-020 Back-to-back: a new request SHALL be accepted no earlier than the IDLE cycle after DONE/FAULT.

Reset
REQ-021 Reset=1 SHALL immediately force IDLE, Ready=1, Done=0, Misaligned=0, OutOfRange=0, MemWrite=0, MemRead=0, Mem_Adress=0, Mem_Write_Data=0, RData=0.
REQ-022 Reset mid-operation SHALL abort it without a Done pulse; a store aborted in READ SHALL leave memory unchanged.

Structure
REQ-023 Op encodings, FSM state encoding and the default DEPTH_WORDS SHALL live in shared package mips_mem_pkg.
REQ-024 Lane extraction/extension and store merge SHALL be one combinational sub-module byte_lane_align.

Verification (memory word 3 preloaded 32'h8899AABB)
REQ-025 LW Addr=0x0C -> MemRead one cycle, Done two cycles after accept, RData=0x8899AABB.
REQ-026 LB Addr=0x0F -> RData=0xFFFFFF88; LBU Addr=0x0F -> 0x00000088; LHU Addr=0x0E -> 0x00008899.
REQ-027 SB Addr=0x0D WData=0x11 -> MemRead one cycle then MemWrite one cycle, word 3=0x889911BB; Done four cycles... no: Done in the cycle after WRITE.
REQ-028 LH Addr=0x0D -> Misaligned=1 with Done one cycle after accept, no MemRead/MemWrite; LW Addr=0x80 -> OutOfRange=1.
REQ-029 Reset asserted during READ of SH Addr=0x0C -> MemRead drops immediately, no Done, word 3 unchanged, Ready=1 after release.
REQ-030 Req held high through a LW -> second request accepted only in the IDLE cycle after DONE; no request lost or duplicated.
